// File: rtl/sort_network_pipelined.sv
// -----------------------------------------------------------------------------
// sort_network_pipelined
//
// Bitonic sorting network for SIZE elements. Each compare-exchange layer has its
// own register stage, so a vector takes L = log2(SIZE)*(log2(SIZE)+1)/2 cycles
// from acceptance to output. A new vector can be accepted every cycle. The whole
// pipeline stalls as one unit while the output is held by the consumer.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    input handshake; vector accepted when both are high
//   data_in, index_in      packed elements (element 0 in the LSBs) and their tags
//   dir_override, dir      when dir_override=1, dir selects direction (1 = ascending);
//                          otherwise UP_DEFAULT applies
//   out_valid / out_ready  output handshake
//   data_out, index_out    sorted elements and tags, element 0 in the LSBs
//   vec_count              wrapping count of delivered vectors
// -----------------------------------------------------------------------------
module sort_network_pipelined #(
   parameter int SIZE       = 8,
   parameter int DATA_W     = 16,
   parameter int IDX_W      = (SIZE > 1) ? $clog2(SIZE) : 1,
   parameter bit UP_DEFAULT = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SIZE*DATA_W-1:0]   data_in,
   input  logic [SIZE*IDX_W-1:0]    index_in,
   input  logic                     dir_override,
   input  logic                     dir,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [SIZE*DATA_W-1:0]   data_out,
   output logic [SIZE*IDX_W-1:0]    index_out,
   output logic [15:0]              vec_count
);

   localparam int LOG = (SIZE < 2) ? 1 : $clog2(SIZE);
   localparam int L   = (LOG * (LOG + 1)) / 2;

   if (SIZE < 2 || (SIZE & (SIZE - 1)) != 0) begin : g_size_check
      $error("sort_network_pipelined: SIZE must be a power of two and at least 2");
   end

   // Layer s belongs to merge phase p (block size 2^p); within a phase the
   // compare distance halves from 2^(p-1) down to 1.
   function automatic int stage_phase(input int s);
      int acc;
      int phase;
      acc   = 0;
      phase = 1;
      for (int p = 1; p <= LOG; p++) begin
         if (s >= acc && s < acc + p) phase = p;
         acc = acc + p;
      end
      return phase;
   endfunction

   function automatic int stage_span(input int s);
      int p;
      p = stage_phase(s);
      return 1 << (p - 1 - (s - (p * (p - 1)) / 2));
   endfunction

   function automatic int stage_block(input int s);
      return 1 << stage_phase(s);
   endfunction

   // Stage registers
   logic [DATA_W-1:0] dat_q [L][SIZE];
   logic [IDX_W-1:0]  idx_q [L][SIZE];
   logic [L-1:0]      vld_q;
   logic [L-1:0]      up_q;
   logic [15:0]       cnt_q;

   // Inputs to each layer (stage 0 sees the ports) and the layer results
   logic [DATA_W-1:0] src_dat [L][SIZE];
   logic [IDX_W-1:0]  src_idx [L][SIZE];
   logic [L-1:0]      src_vld;
   logic [L-1:0]      src_up;
   logic [DATA_W-1:0] dat_d [L][SIZE];
   logic [IDX_W-1:0]  idx_d [L][SIZE];

   logic eff_up;

   assign out_valid = vld_q[L-1];
   assign in_ready  = !(out_valid && !out_ready);
   assign vec_count = cnt_q;

   always_comb begin
      eff_up     = dir_override ? dir : UP_DEFAULT;
      src_vld    = '0;
      src_up     = '0;
      src_vld[0] = in_valid;
      src_up[0]  = eff_up;
      for (int i = 0; i < SIZE; i++) begin
         src_dat[0][i] = data_in[i*DATA_W +: DATA_W];
         src_idx[0][i] = index_in[i*IDX_W +: IDX_W];
      end
      for (int s = 1; s < L; s++) begin
         src_vld[s] = vld_q[s-1];
         src_up[s]  = up_q[s-1];
         for (int i = 0; i < SIZE; i++) begin
            src_dat[s][i] = dat_q[s-1][i];
            src_idx[s][i] = idx_q[s-1][i];
         end
      end
   end

   // Compare-exchange layers. The (data, index) pair is the sort key, so ties
   // on data resolve by index and pairs always move together.
   always_comb begin
      int   partner;
      logic asc;
      logic i_above;
      logic p_above;
      partner = 0;
      asc     = 1'b0;
      i_above = 1'b0;
      p_above = 1'b0;
      for (int s = 0; s < L; s++) begin
         for (int i = 0; i < SIZE; i++) begin
            dat_d[s][i] = src_dat[s][i];
            idx_d[s][i] = src_idx[s][i];
         end
      end
      for (int s = 0; s < L; s++) begin
         for (int i = 0; i < SIZE; i++) begin
            partner = i ^ stage_span(s);
            if (partner > i) begin
               // Sub-blocks alternate direction to build bitonic sequences; the
               // final phase spans the whole vector and uses the vector's own direction.
               asc     = src_up[s] ^ ((i & stage_block(s)) != 0);
               i_above = (src_dat[s][i] > src_dat[s][partner]) ||
                         ((src_dat[s][i] == src_dat[s][partner]) &&
                          (src_idx[s][i] > src_idx[s][partner]));
               p_above = (src_dat[s][partner] > src_dat[s][i]) ||
                         ((src_dat[s][partner] == src_dat[s][i]) &&
                          (src_idx[s][partner] > src_idx[s][i]));
               if (asc ? i_above : p_above) begin
                  dat_d[s][i]       = src_dat[s][partner];
                  idx_d[s][i]       = src_idx[s][partner];
                  dat_d[s][partner] = src_dat[s][i];
                  idx_d[s][partner] = src_idx[s][i];
               end
            end
         end
      end
   end

   // in_ready doubles as the global advance enable. Payload registers only
   // load behind a valid vector so an idle pipeline holds its contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         up_q  <= '0;
         cnt_q <= '0;
         for (int s = 0; s < L; s++) begin
            for (int i = 0; i < SIZE; i++) begin
               dat_q[s][i] <= '0;
               idx_q[s][i] <= '0;
            end
         end
      end else begin
         if (in_ready) begin
            vld_q <= src_vld;
            for (int s = 0; s < L; s++) begin
               if (src_vld[s]) begin
                  up_q[s] <= src_up[s];
                  for (int i = 0; i < SIZE; i++) begin
                     dat_q[s][i] <= dat_d[s][i];
                     idx_q[s][i] <= idx_d[s][i];
                  end
               end
            end
         end
         if (out_valid && out_ready) begin
            cnt_q <= cnt_q + 16'd1;
         end
      end
   end

   genvar gi;
   for (gi = 0; gi < SIZE; gi++) begin : g_out
      assign data_out[gi*DATA_W +: DATA_W] = dat_q[L-1][gi];
      assign index_out[gi*IDX_W +: IDX_W]  = idx_q[L-1][gi];
   end

endmodule

// File: doc/sort_network_pipelined.md
SORT_NETWORK_PIPELINED -- requirements
Module: sort_network_pipelined

Interface
REQ-001 SHALL have parameter SIZE, default 8: number of elements per vector; power of two, >= 2.
REQ-002 SHALL have parameter DATA_W, default NETWORK_WIDTH: element data width.
REQ-003 SHALL have parameter IDX_W, default INDEX_WIDTH: element index width.
REQ-004 SHALL have parameter UP_DEFAULT, default 1: direction used when dir_override is 0 (1 = ascending).
REQ-005 SHALL have ports clk, input, 1, sole clock; reset is asynchronous and active-low.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1: input vector present.
REQ-008 SHALL have port in_ready, output, 1: input vector accepted this cycle when high with in_valid.
REQ-009 SHALL have port data_in, input, SIZE x DATA_W: packed input elements.
REQ-010 SHALL have port index_in, input, SIZE x IDX_W: index tag per element.
REQ-011 SHALL have ports dir_override, input, 1 and dir, input, 1: per-vector direction select; when dir_override is 1, dir applies (1 = ascending).
REQ-012 SHALL have port out_valid, output, 1: sorted vector present.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts.
REQ-014 SHALL have ports data_out, output, SIZE x DATA_W and index_out, output, SIZE x IDX_W: sorted elements and their tags.
REQ-015 SHALL have port vec_count, output, 16: count of vectors delivered (out_valid & out_ready), wrapping.

Function
REQ-016 SHALL implement a bitonic sort of SIZE elements with one register stage per compare-exchange layer: L = log2(SIZE)*(log2(SIZE)+1)/2 stages (SIZE=2:1, 4:3, 8:6, 16:10).
REQ-017 SHALL order ascending as data_out[0] smallest through data_out[SIZE-1] largest; descending is the exact reverse.
REQ-018 SHALL compare on data first and, when data are equal, on index, the lower index being treated as smaller, so output is deterministic for ties.
REQ-019 SHALL move each index with its data element through every exchange; data/index pairs are never separated.
REQ-020 SHALL capture the effective direction with the vector at acceptance and carry it through all stages; the direction of an in-flight vector never changes.
REQ-021 SHALL accept a vector when in_valid & in_ready at a rising edge of clk.
REQ-022 SHALL produce latency exactly L cycles from acceptance to out_valid, when not stalled.
REQ-023 SHALL sustain throughput of one vector per cycle when out_ready is held high.
REQ-024 SHALL stall, when out_valid=1 and out_ready=0, every stage together (global enable), holding all stage contents and outputs stable; in_ready=0 during stall.
REQ-025 SHALL drive in_ready = !(out_valid & !out_ready), combinationally.
REQ-026 SHALL propagate bubbles: a stage with no valid vector advances with valid bit 0; bubbles are not collapsed.
REQ-027 SHALL keep data_out/index_out stable while out_valid=1 and out_ready=0.
REQ-028 SHALL increment vec_count by 1 on each out_valid & out_ready cycle, wrapping 0xFFFF -> 0x0000.
REQ-029 SHALL not increment vec_count, and SHALL hold all state, when in_valid=0 and the pipeline is empty.
REQ-030 SHALL cause a SIZE that is not a power of two or is < 2 to fail elaboration.

Reset
REQ-031 SHALL clear, on rst_n low, all stage valid bits, out_valid, and vec_count to 0, and all data/index/direction registers to 0, asynchronously.
REQ-032 SHALL drive in_ready=1 while rst_n is low and on the first cycle after release.
REQ-033 SHALL discard in-flight vectors when rst_n asserts mid-operation; none appears at the output after release.

Verification
REQ-034 SHALL cover: SIZE=8, ascending, data_in {7,3,5,1,6,2,8,4} index 0..7 -> after 6 cycles data_out[0..7]={1,2,3,4,5,6,7,8}, index_out={3,5,1,7,2,4,0,6}.
REQ-035 SHALL cover: same vector with dir_override=1, dir=0 -> data_out[0..7]={8,7,6,5,4,3,2,1}, index_out reversed accordingly.
REQ-036 SHALL cover: SIZE=4, all data = 9, index {3,0,2,1}, ascending -> index_out={0,1,2,3}.
REQ-037 SHALL cover: SIZE=8, 10 back-to-back vectors with out_ready=1 -> 10 out_valid cycles, contiguous, first at cycle 6, vec_count=10.
REQ-038 SHALL cover: out_ready=0 for 4 cycles with pipeline full -> in_ready=0, outputs unchanged for 4 cycles, no vector lost or duplicated afterward.
REQ-039 SHALL cover: rst_n pulsed low 3 cycles after accepting 2 vectors -> out_valid stays 0, vec_count=0, in_ready=1.
